// File: rtl/muldiv_ctrl_pkg.sv
// Shared SPECIAL function codes and FSM state encoding for the HI/LO multiply/divide unit.
package muldiv_ctrl_pkg;

  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1a;
  localparam logic [5:0] FnDivu  = 6'h1b;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFinish
  } state_e;

  // Ops that occupy the iterative datapath.
  function automatic logic is_iter_op(input logic [5:0] fn);
    return (fn == FnMult) || (fn == FnMultu) || (fn == FnDiv) || (fn == FnDivu);
  endfunction

  function automatic logic is_supported_op(input logic [5:0] fn);
    return is_iter_op(fn) || (fn == FnMfhi) || (fn == FnMflo) || (fn == FnMthi) ||
           (fn == FnMtlo);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
module muldiv_step
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 i_is_div,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_operand,
  output logic [2*WIDTH-1:0]   o_acc
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [2*WIDTH:0] w_shift;

  always_comb begin
    w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
    w_shift = {i_acc, 1'b0};
    // Top bit of the difference set means the trial subtraction borrowed.
    w_diff  = w_shift[2*WIDTH:WIDTH] - {1'b0, i_operand};
    if (i_is_div) begin
      o_acc = w_diff[WIDTH] ? w_shift[2*WIDTH-1:0]
                            : {w_diff[WIDTH-1:0], w_shift[WIDTH-1:1], 1'b1};
    end else begin
      o_acc = i_acc[0] ? {w_sum, i_acc[WIDTH-1:1]} : {1'b0, i_acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide controller: MULT/MULTU/DIV/DIVU plus MFHI/MFLO/MTHI/MTLO.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             w_start,
  input  logic [5:0]       w_op_code_6,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  output logic             w_busy,
  output logic             w_stall,
  output logic [WIDTH-1:0] w_output_x,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x
);

  localparam logic [WIDTH-1:0]   OneW   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] One2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [5:0]         CntLast = 6'(ITER - 1);

  state_e               r_state, w_state_next;
  logic [5:0]           r_cnt, w_cnt_next;
  logic [2*WIDTH-1:0]   r_acc, w_acc_next;
  logic [WIDTH-1:0]     r_opnd, w_opnd_next;
  logic                 r_is_div, w_is_div_next;
  logic                 r_neg_q, w_neg_q_next;
  logic                 r_neg_r, w_neg_r_next;
  logic                 r_div_zero, w_div_zero_next;
  logic [WIDTH-1:0]     r_hi, w_hi_next;
  logic [WIDTH-1:0]     r_lo, w_lo_next;

  logic                 w_is_signed, w_is_div_op;
  logic                 w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0]   w_step_acc;
  logic [2*WIDTH-1:0]   w_prod_res;
  logic [WIDTH-1:0]     w_quot, w_rem, w_quot_res, w_rem_res;

  // Operand decode: signed ops iterate on magnitudes.
  always_comb begin
    w_is_signed = (w_op_code_6 == FnMult) || (w_op_code_6 == FnDiv);
    w_is_div_op = (w_op_code_6 == FnDiv) || (w_op_code_6 == FnDivu);
    w_a_neg     = w_is_signed & w_input1_x[WIDTH-1];
    w_b_neg     = w_is_signed & w_input2_x[WIDTH-1];
    w_a_mag     = w_a_neg ? (~w_input1_x + OneW) : w_input1_x;
    w_b_mag     = w_b_neg ? (~w_input2_x + OneW) : w_input2_x;
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_is_div  (r_is_div),
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .o_acc     (w_step_acc)
  );

  // Sign correction; a zero divisor keeps the all-ones quotient regardless of sign.
  always_comb begin
    w_prod_res = r_neg_q ? (~r_acc + One2W) : r_acc;
    w_quot     = r_acc[WIDTH-1:0];
    w_rem      = r_acc[2*WIDTH-1:WIDTH];
    w_quot_res = (r_neg_q && !r_div_zero) ? (~w_quot + OneW) : w_quot;
    w_rem_res  = r_neg_r ? (~w_rem + OneW) : w_rem;
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_acc_next      = r_acc;
    w_opnd_next     = r_opnd;
    w_is_div_next   = r_is_div;
    w_neg_q_next    = r_neg_q;
    w_neg_r_next    = r_neg_r;
    w_div_zero_next = r_div_zero;
    w_hi_next       = r_hi;
    w_lo_next       = r_lo;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          if (is_iter_op(w_op_code_6)) begin
            w_acc_next      = {{WIDTH{1'b0}}, (w_is_div_op ? w_a_mag : w_b_mag)};
            w_opnd_next     = w_is_div_op ? w_b_mag : w_a_mag;
            w_is_div_next   = w_is_div_op;
            w_neg_q_next    = w_a_neg ^ w_b_neg;
            w_neg_r_next    = w_a_neg;
            w_div_zero_next = w_is_div_op && (w_input2_x == '0);
            w_cnt_next      = '0;
            w_state_next    = StIter;
          end else if (w_op_code_6 == FnMthi) begin
            w_hi_next = w_input1_x;
          end else if (w_op_code_6 == FnMtlo) begin
            w_lo_next = w_input1_x;
          end
        end
      end
      StIter: begin
        w_acc_next = w_step_acc;
        w_cnt_next = r_cnt + 6'd1;
        if (r_cnt == CntLast) begin
          w_state_next = StFinish;
        end
      end
      StFinish: begin
        if (r_is_div) begin
          w_hi_next = w_rem_res;
          w_lo_next = w_quot_res;
        end else begin
          w_hi_next = w_prod_res[2*WIDTH-1:WIDTH];
          w_lo_next = w_prod_res[WIDTH-1:0];
        end
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_acc      <= w_acc_next;
      r_opnd     <= w_opnd_next;
      r_is_div   <= w_is_div_next;
      r_neg_q    <= w_neg_q_next;
      r_neg_r    <= w_neg_r_next;
      r_div_zero <= w_div_zero_next;
      r_hi       <= w_hi_next;
      r_lo       <= w_lo_next;
    end
  end

  always_comb begin
    w_busy  = (r_state != StIdle);
    w_stall = w_busy && w_start && is_supported_op(w_op_code_6);
    w_hi_x  = r_hi;
    w_lo_x  = r_lo;
    if (w_op_code_6 == FnMfhi) begin
      w_output_x = r_hi;
    end else if (w_op_code_6 == FnMflo) begin
      w_output_x = r_lo;
    end else begin
      w_output_x = '0;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus queues expected HI/LO, a monitor checks on completion.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clock;
  logic        reset;
  logic        w_start;
  logic [5:0]  w_op_code_6;
  logic [31:0] w_input1_x;
  logic [31:0] w_input2_x;
  logic        w_busy;
  logic        w_stall;
  logic [31:0] w_output_x;
  logic [31:0] w_hi_x;
  logic [31:0] w_lo_x;

  muldiv_ctrl #(
    .WIDTH(32),
    .ITER (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .w_start    (w_start),
    .w_op_code_6(w_op_code_6),
    .w_input1_x (w_input1_x),
    .w_input2_x (w_input2_x),
    .w_busy     (w_busy),
    .w_stall    (w_stall),
    .w_output_x (w_output_x),
    .w_hi_x     (w_hi_x),
    .w_lo_x     (w_lo_x)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors;
  int    checks;
  bit    aborting;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    w_start     = 1'b1;
    w_op_code_6 = op;
    w_input1_x  = a;
    w_input2_x  = b;
    tick();
    w_start = 1'b0;
  endtask

  task automatic expect_res(input string nm, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d results pending, required 0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
    tick();
  endtask

  // Monitor: every busy->idle transition outside an abort is a completed operation.
  initial begin
    bit    prev_busy;
    int    busy_cycles;
    exp_t  e;
    string nm;
    prev_busy   = 1'b0;
    busy_cycles = 0;
    forever begin
      @(negedge clock);
      if (w_busy === 1'b1) begin
        busy_cycles++;
      end else begin
        if (prev_busy && !aborting) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected completion: got hi=%h lo=%h, required none", w_hi_x,
                     w_lo_x);
          end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check({nm, " hi"}, w_hi_x, e.hi);
            check({nm, " lo"}, w_lo_x, e.lo);
            check({nm, " busy cycles"}, busy_cycles, 32'd33);
          end
        end
        busy_cycles = 0;
      end
      prev_busy = (w_busy === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    int stall_cnt;
    errors      = 0;
    checks      = 0;
    aborting    = 1'b0;
    reset       = 1'b1;
    w_start     = 1'b0;
    w_op_code_6 = 6'h00;
    w_input1_x  = '0;
    w_input2_x  = '0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("reset busy", w_busy, 0);
    check("reset hi", w_hi_x, 0);
    check("reset lo", w_lo_x, 0);
    check("reset stall", w_stall, 0);
    tick();

    // MULTU all-ones: result appears exactly at edge 33.
    expect_res("multu ffff", 32'hFFFFFFFE, 32'h00000001);
    issue(FnMultu, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (32) tick();
    check("multu lo before edge33", w_lo_x, 0);
    check("multu busy before edge33", w_busy, 1);
    tick();
    check("multu lo at edge33", w_lo_x, 32'h00000001);
    check("multu busy at edge33", w_busy, 0);
    wait_done("multu ffff");

    expect_res("mult -3x7", 32'hFFFFFFFF, 32'hFFFFFFEB);
    issue(FnMult, 32'hFFFFFFFD, 32'd7);
    wait_done("mult -3x7");
    expect_res("mult max x -1", 32'hFFFFFFFF, 32'h80000001);
    issue(FnMult, 32'h7FFFFFFF, 32'hFFFFFFFF);
    wait_done("mult max x -1");
    expect_res("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(FnDiv, 32'hFFFFFFF9, 32'd2);
    wait_done("div -7/2");
    expect_res("divu 7/0", 32'h00000007, 32'hFFFFFFFF);
    issue(FnDivu, 32'd7, 32'd0);
    wait_done("divu 7/0");
    expect_res("div -5/0", 32'hFFFFFFFB, 32'hFFFFFFFF);
    issue(FnDiv, 32'hFFFFFFFB, 32'd0);
    wait_done("div -5/0");
    expect_res("div min/-1", 32'h00000000, 32'h80000000);
    issue(FnDiv, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div min/-1");

    // MFLO held with start during a MULTU stalls until FINISH completes.
    expect_res("multu 3x5", 32'h0, 32'd15);
    issue(FnMultu, 32'd3, 32'd5);
    repeat (4) tick();
    w_start     = 1'b1;
    w_op_code_6 = FnMflo;
    stall_cnt   = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (w_busy !== 1'b1) break;
      if (w_stall === 1'b1) stall_cnt++;
    end
    check("mflo stall cycles", stall_cnt, 32'd29);
    check("mflo stall after finish", w_stall, 0);
    check("mflo output", w_output_x, 32'd15);
    tick();
    w_start = 1'b0;
    wait_done("multu 3x5");

    // Second start mid-DIVU is ignored.
    expect_res("divu 100/7", 32'd2, 32'd14);
    issue(FnDivu, 32'd100, 32'd7);
    repeat (9) tick();
    w_start     = 1'b1;
    w_op_code_6 = FnMult;
    w_input1_x  = 32'd2;
    w_input2_x  = 32'd3;
    @(negedge clock);
    check("stall on busy start", w_stall, 1);
    tick();
    w_start = 1'b0;
    wait_done("divu 100/7");
    repeat (3) tick();
    check("no restart after divu", w_busy, 0);

    // Unsupported op code while busy: no stall, no effect.
    expect_res("multu 1x1", 32'h0, 32'h1);
    issue(FnMultu, 32'd1, 32'd1);
    repeat (3) tick();
    w_start     = 1'b1;
    w_op_code_6 = 6'h20;
    @(negedge clock);
    check("stall unsupported", w_stall, 0);
    tick();
    w_start = 1'b0;
    wait_done("multu 1x1");

    // MTHI/MTLO and MFHI/MFLO read path.
    issue(FnMthi, 32'hAAAA5555, 32'h0);
    check("mthi hi", w_hi_x, 32'hAAAA5555);
    issue(FnMtlo, 32'h12345678, 32'h0);
    check("mtlo lo", w_lo_x, 32'h12345678);
    w_op_code_6 = FnMfhi;
    #1;
    check("mfhi output", w_output_x, 32'hAAAA5555);
    w_op_code_6 = FnMflo;
    #1;
    check("mflo output idle", w_output_x, 32'h12345678);
    w_op_code_6 = FnMult;
    #1;
    check("output other op", w_output_x, 0);

    // Reset at cycle 20 of a MULT aborts it; a new start is accepted right away.
    issue(FnMult, 32'd9, 32'd9);
    repeat (19) tick();
    aborting = 1'b1;
    reset    = 1'b1;
    tick();
    reset       = 1'b0;
    w_start     = 1'b1;
    w_op_code_6 = FnMultu;
    w_input1_x  = 32'd6;
    w_input2_x  = 32'd7;
    @(negedge clock);
    check("abort busy", w_busy, 0);
    check("abort hi", w_hi_x, 0);
    check("abort lo", w_lo_x, 0);
    expect_res("multu 6x7 after reset", 32'h0, 32'd42);
    tick();
    w_start  = 1'b0;
    aborting = 1'b0;
    wait_done("multu 6x7 after reset");

    // Reset wins over a same-edge start.
    reset       = 1'b1;
    w_start     = 1'b1;
    w_op_code_6 = FnMult;
    w_input1_x  = 32'd2;
    w_input2_x  = 32'd3;
    tick();
    reset   = 1'b0;
    w_start = 1'b0;
    @(negedge clock);
    check("reset priority busy", w_busy, 0);
    check("reset priority lo", w_lo_x, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
